// File: rtl/fe_capture_sequencer_pkg.sv
// Shared constants for the front-end capture sequencer: FIFO command
// encodings, sequencer state encoding and a small width helper.
package fe_capture_sequencer_pkg;

  localparam logic [1:0] FE_FIFO_CMD_DATA = 2'b00;
  localparam logic [1:0] FE_FIFO_CMD_STAT = 2'b01;
  localparam logic [1:0] FE_FIFO_CMD_TIME = 2'b10;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StCapture = 2'd2,
    StDone    = 2'd3
  } fe_state_e;

  function automatic int unsigned max_width(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fe_capture_sequencer_if.sv
// Datapath-side bundle of the capture sequencer: event/command inputs coming
// from fe_capture_usb and the FIFO write port going back to it.
// master: the sequencer. slave: the datapath.
interface fe_capture_sequencer_if #(
  parameter int unsigned pTIMESTAMP_FULL_WIDTH = 16
) ();

  logic                             I_event;
  logic [1:0]                       I_data_cmd;
  logic [15:0]                      I_max_short_timestamp;
  logic                             I_fifo_write_allowed;
  logic [pTIMESTAMP_FULL_WIDTH-1:0] O_fifo_time;
  logic [1:0]                       O_fifo_command;
  logic                             O_fifo_wr;

  modport master (
    input  I_event,
    input  I_data_cmd,
    input  I_max_short_timestamp,
    input  I_fifo_write_allowed,
    output O_fifo_time,
    output O_fifo_command,
    output O_fifo_wr
  );

  modport slave (
    output I_event,
    output I_data_cmd,
    output I_max_short_timestamp,
    output I_fifo_write_allowed,
    input  O_fifo_time,
    input  O_fifo_command,
    input  O_fifo_wr
  );

endinterface

// File: rtl/fe_timestamp_counter.sv
// Inter-event timestamp counter. t_now_o is the number of edges since the
// last clear, counting the current edge, saturating at all-ones; is_long_o
// flags that this gap no longer fits the short-time encoding.
module fe_timestamp_counter
  import fe_capture_sequencer_pkg::*;
#(
  parameter int unsigned pTIMESTAMP_FULL_WIDTH  = 16,
  parameter int unsigned pTIMESTAMP_SHORT_WIDTH = 3
) (
  input  logic                             fe_clk,
  input  logic                             reset_i,
  input  logic                             clear_i,
  input  logic [15:0]                      max_short_i,
  output logic [pTIMESTAMP_FULL_WIDTH-1:0] t_now_o,
  output logic                             is_long_o
);

  // Wide enough for the counter, the 16-bit limit and any short field.
  localparam int unsigned CmpW =
    max_width(max_width(pTIMESTAMP_FULL_WIDTH, 16), pTIMESTAMP_SHORT_WIDTH + 1);

  logic [pTIMESTAMP_FULL_WIDTH-1:0] t_q;

  // Saturating increment; t_q holds the count up to the previous edge.
  always_comb begin
    t_now_o   = (t_q == '1) ? t_q : t_q + 1'b1;
    is_long_o = CmpW'(t_now_o) > CmpW'(max_short_i);
  end

  // Counter register: cleared on trigger/arm/accepted event.
  always_ff @(posedge fe_clk) begin
    if (reset_i || clear_i) begin
      t_q <= '0;
    end else begin
      t_q <= t_now_o;
    end
  end

endmodule

// File: rtl/fe_capture_sequencer.sv
// Capture controller for the USB front-end: arm/trigger/capture/done
// sequencing, per-event FIFO command selection and long-gap TIME entries.
// Optional build macro FE_CAPTURE_LEN_EN adds the write-count limit and the
// CAPTURE -> DONE stop; without it I_capture_len is ignored and O_done is 0.
module fe_capture_sequencer
  import fe_capture_sequencer_pkg::*;
#(
  parameter int unsigned pTIMESTAMP_FULL_WIDTH  = 16,
  parameter int unsigned pTIMESTAMP_SHORT_WIDTH = 3,
  parameter int unsigned pCAPTURE_LEN_WIDTH     = 24
) (
  input  logic                          fe_clk,
  input  logic                          reset_i,
  input  logic                          I_arm,
  input  logic                          I_trigger,
  input  logic [pCAPTURE_LEN_WIDTH-1:0] I_capture_len,
  fe_capture_sequencer_if.master        fifo_if,
  output logic                          O_capturing,
  output logic                          O_done,
  output logic                          O_overflow
);

  localparam int unsigned TW = pTIMESTAMP_FULL_WIDTH;

  fe_state_e state_q, state_d;
  logic      arm_q;

  logic keep_going, arm_rise, trig_start, ev_take;
  logic [TW-1:0] ts_now;
  logic          ts_long;

  // Stage 1: event accepted last edge. Stage 2: data/stat slot pending.
  logic          s1_valid_q, s1_long_q;
  logic [TW-1:0] s1_time_q;
  logic          s2_valid_q;
  logic [TW-1:0] s2_time_q;

  logic          want_time, want_data, issue;
  logic [TW-1:0] slot_time;
  logic          wr_q, slot_is_time_q;
  logic [TW-1:0] time_q;

  logic overflow_q, capturing_q;
  logic limit_hit, done_hit;

  assign keep_going = (state_q == StCapture) && I_arm;
  assign arm_rise   = (state_q == StIdle) && I_arm && !arm_q;
  assign trig_start = (state_q == StArmed) && I_arm && I_trigger;
  assign ev_take    = keep_going && fifo_if.I_event;

  fe_timestamp_counter #(
    .pTIMESTAMP_FULL_WIDTH  (pTIMESTAMP_FULL_WIDTH),
    .pTIMESTAMP_SHORT_WIDTH (pTIMESTAMP_SHORT_WIDTH)
  ) u_ts (
    .fe_clk      (fe_clk),
    .reset_i     (reset_i),
    .clear_i     (arm_rise || trig_start || ev_take),
    .max_short_i (fifo_if.I_max_short_timestamp),
    .t_now_o     (ts_now),
    .is_long_o   (ts_long)
  );

  // Slot selection. A long event's TIME slot can never meet another event's
  // data slot while max short >= 1; data wins should that ever be violated.
  always_comb begin
    want_time = s1_valid_q && s1_long_q;
    want_data = s2_valid_q;
    slot_time = want_data ? s2_time_q : s1_time_q;
    issue     = keep_going && (want_time || want_data) && !limit_hit;
  end

`ifdef FE_CAPTURE_LEN_EN
  logic [pCAPTURE_LEN_WIDTH-1:0] count_q;
  logic                          done_q;

  always_comb begin
    limit_hit = (I_capture_len != '0) && (count_q >= I_capture_len);
    done_hit  = issue && (I_capture_len != '0) &&
                (({1'b0, count_q} + 1'b1) >= {1'b0, I_capture_len});
  end

  // Write counter, TIME entries included; restarts on every arm.
  always_ff @(posedge fe_clk) begin
    if (reset_i || arm_rise) begin
      count_q <= '0;
    end else if (issue) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Registered DONE decode.
  always_ff @(posedge fe_clk) begin
    if (reset_i) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (state_d == StDone);
    end
  end

  assign O_done = done_q;
`else
  logic unused_capture_len;

  assign unused_capture_len = ^I_capture_len;
  assign limit_hit          = 1'b0;
  assign done_hit           = 1'b0;
  assign O_done             = 1'b0;
`endif

  // Next-state logic; dropping I_arm wins from any state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (arm_rise)   state_d = StArmed;
      StArmed:   if (trig_start) state_d = StCapture;
      StCapture: if (done_hit)   state_d = StDone;
      StDone:    state_d = StDone;
      default:   state_d = StIdle;
    endcase
    if (!I_arm) state_d = StIdle;
  end

  // State, arm edge detector, status decodes and sticky overflow.
  always_ff @(posedge fe_clk) begin
    if (reset_i) begin
      state_q     <= StIdle;
      arm_q       <= 1'b0;
      capturing_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      arm_q       <= I_arm;
      capturing_q <= (state_d == StCapture);
      if (arm_rise) begin
        overflow_q <= 1'b0;
      end else if (wr_q && !fifo_if.I_fifo_write_allowed) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Event pipeline and registered write port; leaving CAPTURE flushes it.
  always_ff @(posedge fe_clk) begin
    if (reset_i) begin
      s1_valid_q     <= 1'b0;
      s1_long_q      <= 1'b0;
      s1_time_q      <= '0;
      s2_valid_q     <= 1'b0;
      s2_time_q      <= '0;
      wr_q           <= 1'b0;
      slot_is_time_q <= 1'b0;
      time_q         <= '0;
    end else begin
      s1_valid_q     <= ev_take;
      s1_long_q      <= ts_long;
      s1_time_q      <= ts_now;
      s2_valid_q     <= s1_valid_q && keep_going;
      s2_time_q      <= s1_long_q ? '0 : s1_time_q;
      wr_q           <= issue;
      slot_is_time_q <= issue && !want_data;
      time_q         <= issue ? slot_time : '0;
    end
  end

  // Data-slot command is I_data_cmd as presented in that very cycle.
  always_comb begin
    fifo_if.O_fifo_command = 2'b00;
    if (wr_q) begin
      fifo_if.O_fifo_command = slot_is_time_q ? FE_FIFO_CMD_TIME : fifo_if.I_data_cmd;
    end
  end

  assign fifo_if.O_fifo_wr   = wr_q;
  assign fifo_if.O_fifo_time = time_q;
  assign O_capturing         = capturing_q;
  assign O_overflow          = overflow_q;

endmodule
